mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single memory access port (mem read1 + write port) between two requesters:
//   M0 = CPU data port, M1 = DMA/loader engine (framebuffer fill, program load).
//   One access issued per cycle; round-robin fairness with bounded lock for atomic sequences.
//   Routes read data back to the issuing requester after the memory's fixed read latency.
// PARAMETERS
//   ADDR_W        16  address width
//   DATA_W        16  data width
//   READ_LATENCY  1   cycles from mem_ren issue to valid mem_rdata (1..4)
//   LOCK_MAX      8   max consecutive grants one locked requester may hold while other waits
// PORTS
//   clk           in   1       system clock, all logic on posedge
//   reset_n       in   1       asynchronous, active-low reset
//   m0_req        in   1       M0 access request; held with m0_we/addr/wdata until granted
//   m0_we         in   1       1 = write, 0 = read
//   m0_lock       in   1       M0 keeps grant on next cycle (bounded by LOCK_MAX)
//   m0_addr       in   ADDR_W  M0 address
//   m0_wdata      in   DATA_W  M0 write data
//   m0_gnt        out  1       M0 access issued this cycle (combinational)
//   m0_rvalid     out  1       M0 read data valid on m0_rdata this cycle
//   m0_rdata      out  DATA_W  read data (broadcast of mem_rdata)
//   m1_*          —    —       identical set for M1
//   mem_ren       out  1       memory read enable
//   mem_raddr     out  ADDR_W  memory read address
//   mem_rdata     in   DATA_W  memory read data, READ_LATENCY after mem_ren
//   mem_wen       out  1       memory write enable
//   mem_waddr     out  ADDR_W  memory write address
//   mem_wdata     out  DATA_W  memory write data
// BEHAVIOUR
//   Reset (reset_n low, async): last_owner=M1 (so M0 wins first tie), lock_cnt=0,
//     locked=0, read tag pipeline cleared; gnt, rvalid, mem_ren, mem_wen forced 0 while low.
//   Handshake: access transfers on posedge where mX_req & mX_gnt; gnt never without req.
//   Arbitration (combinational from req + regs): only one req -> grant it; both req ->
//     if locked owner and lock_cnt<LOCK_MAX grant owner, else grant requester != last_owner.
//   Lock: owner granted with mX_lock=1 sets locked, lock_cnt increments per grant while the
//     other requester waits (saturates at LOCK_MAX; reaching it forces switch on next tie).
//     Lock released when owner drops lock or req; lock_cnt cleared on owner change or release.
//     Lock with no competing req: no counting, no forced switch.
//   Issue: granted read -> mem_ren=1, mem_raddr=addr, mem_wen=0. Granted write ->
//     mem_wen=1, mem_waddr/mem_wdata from requester, mem_ren=0. No grant -> both enables 0.
//     Address/data outputs carry granted requester's values; don't-care when idle.
//   Read return: READ_LATENCY-deep shift register of {valid, owner}; mX_rvalid=1 exactly
//     READ_LATENCY cycles after read grant, only for issuing requester. Writes produce no rvalid.
//   Ordering: accesses execute in grant order; write then read same addr from either
//     requester in consecutive cycles returns new data (memory is write-first in issue order).
//   Back-to-back reads: one per cycle sustained, rvalids return in order, no bubbles.
//   Reset mid-operation: in-flight reads discarded, no rvalid after reset release.
// TESTING
//   1. M0 read 0x0010 alone (mem[0x10]=0xBEEF) -> m0_gnt same cycle, m0_rvalid+0xBEEF
//      after READ_LATENCY cycles, m1_rvalid stays 0.
//   2. M0,M1 both req reads continuously for 6 cycles from reset -> grants M0,M1,M0,M1,M0,M1;
//      each rvalid to correct owner in order.
//   3. M1 lock=1 with M0 waiting, LOCK_MAX=8 -> M1 granted 8 consecutive cycles, then M0.
//   4. M0 write 0x1234 to 0x0200 then M1 read 0x0200 next cycle -> m1_rdata=0x1234,
//      no m0_rvalid for the write.
//   5. Issue 2 reads with READ_LATENCY=3, pulse reset_n low before return -> no rvalid
//      afterwards; first post-reset tie grants M0.
//   6. No requests -> mem_ren=mem_wen=0 every cycle, both gnt=0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: one requester's access channel into the memory port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory read/write port between two requesters with
// round-robin fairness, bounded lock for atomic runs, and tagged read-data return.
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1,
    parameter int LOCK_MAX     = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_port_arbiter_if.slave   m0,
    mem_port_arbiter_if.slave   m1,
    output logic                mem_ren,
    output logic [ADDR_W-1:0]   mem_raddr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [DATA_W-1:0]   mem_wdata
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);
    logic                    r_last;
    logic                    r_locked;
    logic [CW-1:0]           r_cnt;
    logic [READ_LATENCY-1:0] r_vld;
    logic [READ_LATENCY-1:0] r_own;
    logic                    w_sel;
    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_any;
    logic                    w_we;
    logic                    w_lock;
    logic                    w_other;
    logic [ADDR_W-1:0]       w_addr;
    logic [CW-1:0]           w_cnt_base;
    logic [CW-1:0]           w_cnt_nxt;
    // w_sel picks the candidate requester (1 = M1); the lock only sways ties
    always_comb begin
        w_sel      = (m0.req & m1.req) ? ((r_locked & (r_cnt < LMAX)) ? r_last : ~r_last) : m1.req;
        w_gnt0     = reset_n & m0.req & ~w_sel;
        w_gnt1     = reset_n & m1.req & w_sel;
        w_any      = w_gnt0 | w_gnt1;
        w_we       = w_sel ? m1.we : m0.we;
        w_lock     = w_sel ? m1.lock : m0.lock;
        w_other    = w_sel ? m0.req : m1.req;
        w_addr     = w_sel ? m1.addr : m0.addr;
        w_cnt_base = (w_sel == r_last && w_lock) ? r_cnt : '0;
        w_cnt_nxt  = (w_lock & w_other & (w_cnt_base != LMAX)) ? w_cnt_base + 1'b1 : w_cnt_base;
    end
    assign m0.gnt    = w_gnt0;
    assign m1.gnt    = w_gnt1;
    assign mem_ren   = w_any & ~w_we;
    assign mem_wen   = w_any & w_we;
    assign mem_raddr = w_addr;
    assign mem_waddr = w_addr;
    assign mem_wdata = w_sel ? m1.wdata : m0.wdata;
    assign m0.rvalid = r_vld[READ_LATENCY-1] & ~r_own[READ_LATENCY-1];
    assign m1.rvalid = r_vld[READ_LATENCY-1] & r_own[READ_LATENCY-1];
    assign m0.rdata  = mem_rdata;
    assign m1.rdata  = mem_rdata;
    // Idle cycle means the lock owner dropped its request, which releases the lock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last   <= 1'b1;
            r_locked <= 1'b0;
            r_cnt    <= '0;
            r_vld    <= '0;
            r_own    <= '0;
        end else begin
            r_vld[0] <= mem_ren;
            r_own[0] <= w_sel;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_own[i] <= r_own[i-1];
            end
            if (w_any) begin
                r_last   <= w_sel;
                r_locked <= w_lock;
                r_cnt    <= w_cnt_nxt;
            end else begin
                r_locked <= 1'b0;
                r_cnt    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a behavioural memory
// (READ_LATENCY=3, LOCK_MAX=8).
module tb_mem_port_arbiter;
    localparam int RL = 3;
    typedef struct {
        logic        own;
        logic [15:0] data;
        int          due;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_ren;
    logic [15:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic        mem_wen;
    logic [15:0] mem_waddr;
    logic [15:0] mem_wdata;
    logic [15:0] mem [0:4095];
    logic [15:0] exp_mem [0:4095];
    logic [15:0] pipe [0:RL-1];
    exp_t        sb[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) m0 ();
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) m1 ();
    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(RL), .LOCK_MAX(8)) dut (
        .clk(clk), .reset_n(reset_n), .m0(m0), .m1(m1),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        pipe[0] <= mem[mem_raddr[11:0]];
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        if (mem_wen) mem[mem_waddr[11:0]] = mem_wdata;
    end
    assign mem_rdata = pipe[RL-1];
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask
    // Read returns: owner, data and exact arrival cycle against the queued expectation
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
            check("rv_miss", cyc, sb[0].due);
            void'(sb.pop_front());
        end
        if (m0.rvalid | m1.rvalid) begin
            if (sb.size() == 0) check("rv_unexp", {m1.rvalid, m0.rvalid}, 2'b00);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("rv_own", {m1.rvalid, m0.rvalid}, e.own ? 2'b10 : 2'b01);
                check("rdata", e.own ? m1.rdata : m0.rdata, e.data);
                check("rv_cyc", cyc, e.due);
            end
        end
    end
    task automatic step(input logic g0, input logic g1);
        logic        own;
        logic        we;
        logic [15:0] a;
        logic [15:0] wd;
        @(negedge clk);
        check("gnt0", m0.gnt, g0);
        check("gnt1", m1.gnt, g1);
        check("ren", mem_ren, (g0 & ~m0.we) | (g1 & ~m1.we));
        check("wen", mem_wen, (g0 & m0.we) | (g1 & m1.we));
        own = g1;
        we  = g1 ? m1.we : m0.we;
        a   = g1 ? m1.addr : m0.addr;
        wd  = g1 ? m1.wdata : m0.wdata;
        if ((g0 | g1) && we) begin
            check("waddr", mem_waddr, a);
            check("wdata", mem_wdata, wd);
            exp_mem[a[11:0]] = wd;
        end else if (g0 | g1) begin
            check("raddr", mem_raddr, a);
            sb.push_back('{own, exp_mem[a[11:0]], cyc + RL});
        end
        @(posedge clk);
        #1;
        if ((g0 | g1) && !we) begin
            if (own) m1.addr = m1.addr + 16'd1;
            else m0.addr = m0.addr + 16'd1;
        end
    endtask
    task automatic drain();
        m0.req = 1'b0;
        m1.req = 1'b0;
        for (int i = 0; i < RL + 2; i++) step(1'b0, 1'b0);
        check("sb_empty", sb.size(), 0);
    endtask
    task automatic do_reset();
        reset_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 16'(i * 7 + 3);
            exp_mem[i] = 16'(i * 7 + 3);
        end
        mem[16]     = 16'hBEEF;
        exp_mem[16] = 16'hBEEF;
        {m0.req, m0.we, m0.lock, m0.addr, m0.wdata} = '0;
        {m1.req, m1.we, m1.lock, m1.addr, m1.wdata} = '0;
        m0.req = 1'b1;
        m1.req = 1'b1;
        @(negedge clk);
        check("rst_gnt0", m0.gnt, 1'b0);
        check("rst_gnt1", m1.gnt, 1'b0);
        check("rst_ren", mem_ren, 1'b0);
        check("rst_rv", {m1.rvalid, m0.rvalid}, 2'b00);
        m0.req = 1'b0;
        m1.req = 1'b0;
        @(posedge clk);
        #1 do_reset();
        // Idle port
        repeat (3) step(1'b0, 1'b0);
        // Single M0 read of preloaded 0xBEEF
        m0.addr = 16'h0010;
        m0.req  = 1'b1;
        step(1'b1, 1'b0);
        drain();
        // Alternation from reset, M0 first
        do_reset();
        m0.addr = 16'h0020;
        m1.addr = 16'h0030;
        m0.req  = 1'b1;
        m1.req  = 1'b1;
        for (int k = 0; k < 6; k++) step(k % 2 == 0, k % 2 == 1);
        drain();
        // M1 locked alone (no counting), then 8 grants while M0 waits
        m1.addr = 16'h0100;
        m0.addr = 16'h0180;
        m1.lock = 1'b1;
        m1.req  = 1'b1;
        repeat (10) step(1'b0, 1'b1);
        m0.req = 1'b1;
        repeat (8) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        m0.req = 1'b0;
        step(1'b0, 1'b1);
        m1.lock = 1'b0;
        m0.req  = 1'b1;
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        drain();
        // Write by M0 then read by M1 of the same address
        m0.we    = 1'b1;
        m0.addr  = 16'h0200;
        m0.wdata = 16'h1234;
        m0.req   = 1'b1;
        step(1'b1, 1'b0);
        m0.req  = 1'b0;
        m0.we   = 1'b0;
        m1.addr = 16'h0200;
        m1.req  = 1'b1;
        step(1'b0, 1'b1);
        drain();
        check("wr_mem", exp_mem[12'h200], 16'h1234);
        // Reset with reads in flight
        m0.addr = 16'h0040;
        m0.req  = 1'b1;
        step(1'b1, 1'b0);
        m0.req  = 1'b0;
        m1.addr = 16'h0050;
        m1.req  = 1'b1;
        step(1'b0, 1'b1);
        m1.req = 1'b0;
        do_reset();
        repeat (5) step(1'b0, 1'b0);
        m0.req = 1'b1;
        m1.req = 1'b1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
